// File: rtl/elevator_pkg.sv
//----------------------------------------------------------------------------
// Module   : elevator_pkg
// Brief    : Shared state enum and output encodings for the elevator slice.
// Revision : 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

package elevator_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_MOVE_UP    = 3'd1,
        ST_MOVE_DOWN  = 3'd2,
        ST_DOOR_OPEN  = 3'd3,
        ST_DOOR_CLOSE = 3'd4
    } state_t;

    localparam logic [1:0] c_door_closed  = 2'b00;
    localparam logic [1:0] c_door_open    = 2'b01;
    localparam logic [1:0] c_door_closing = 2'b10;

    localparam logic [1:0] c_wait_moving  = 2'b00;
    localparam logic [1:0] c_wait_idle    = 2'b01;
    localparam logic [1:0] c_wait_serving = 2'b10;

endpackage

`default_nettype wire

// File: rtl/elevator_timer.sv
//----------------------------------------------------------------------------
// Module   : elevator_timer
// Brief    : Loadable down-counter; done is high while enabled at zero.
// Revision : 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

module elevator_timer #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             enable,
    output logic             done
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_value;
        end else if (enable && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign done = enable && (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/elevator_controller.sv
//----------------------------------------------------------------------------
// Module   : elevator_controller
// Brief    : Single-car controller: latch target, travel, timed door cycle.
//            Option CONTROLLER_REQ_CLAMP_EN clamps out-of-range requests.
// Revision : 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

module elevator_controller
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS   = 32,
    parameter int FLOOR_CYCLES = 4,
    parameter int DOOR_CYCLES  = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] requested_floor,
    output logic [1:0] wait_floor,
    output logic [1:0] door,
    output logic [1:0] Up,
    output logic [1:0] Down,
    output logic [4:0] y
);

    localparam int c_travel_w = (FLOOR_CYCLES > 1) ? $clog2(FLOOR_CYCLES) : 1;
    localparam int c_door_w   = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
    localparam logic [c_travel_w-1:0] c_travel_load = c_travel_w'(FLOOR_CYCLES - 1);
    localparam logic [c_door_w-1:0]   c_door_load   = c_door_w'(DOOR_CYCLES - 1);
    localparam logic [5:0] c_num_floors = 6'(NUM_FLOORS);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [4:0] r_target;
    logic [4:0] w_target_nxt;
    logic [4:0] w_y_nxt;
    logic [4:0] w_req;
    logic       w_req_valid;
    logic       w_moving;
    logic       w_travel_done;
    logic       w_door_done;

    assign w_moving = (r_state == ST_MOVE_UP) || (r_state == ST_MOVE_DOWN);

`ifdef CONTROLLER_REQ_CLAMP_EN
    assign w_req_valid = 1'b1;
    assign w_req = ({1'b0, requested_floor} < c_num_floors) ? requested_floor
                                                            : 5'(NUM_FLOORS - 1);
`else
    assign w_req_valid = ({1'b0, requested_floor} < c_num_floors);
    assign w_req       = requested_floor;
`endif

    // Travel timer is held loaded while idle so each floor takes a full period.
    elevator_timer #(.WIDTH(c_travel_w)) u_travel_timer (
        .clk        (clk),
        .reset      (reset),
        .load       ((r_state == ST_IDLE) || w_travel_done),
        .load_value (c_travel_load),
        .enable     (w_moving),
        .done       (w_travel_done)
    );

    elevator_timer #(.WIDTH(c_door_w)) u_door_timer (
        .clk        (clk),
        .reset      (reset),
        .load       (r_state != ST_DOOR_OPEN),
        .load_value (c_door_load),
        .enable     (r_state == ST_DOOR_OPEN),
        .done       (w_door_done)
    );

    always_comb begin
        w_state_nxt  = r_state;
        w_y_nxt      = y;
        w_target_nxt = r_target;
        case (r_state)
            ST_IDLE: begin
                if (w_req_valid && (w_req != y)) begin
                    w_target_nxt = w_req;
                    w_state_nxt  = (w_req > y) ? ST_MOVE_UP : ST_MOVE_DOWN;
                end
            end
            ST_MOVE_UP: begin
                if (w_travel_done) begin
                    w_y_nxt = y + 5'd1;
                    if ((y + 5'd1) == r_target) w_state_nxt = ST_DOOR_OPEN;
                end
            end
            ST_MOVE_DOWN: begin
                if (w_travel_done) begin
                    w_y_nxt = y - 5'd1;
                    if ((y - 5'd1) == r_target) w_state_nxt = ST_DOOR_OPEN;
                end
            end
            ST_DOOR_OPEN: begin
                if (w_door_done) w_state_nxt = ST_DOOR_CLOSE;
            end
            ST_DOOR_CLOSE: w_state_nxt = ST_IDLE;
            default:       w_state_nxt = ST_IDLE;
        endcase
    end

    // Outputs are decoded from next-state values so they align with the state register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_target   <= 5'd0;
            y          <= 5'd0;
            door       <= c_door_closed;
            wait_floor <= c_wait_idle;
            Up         <= 2'b00;
            Down       <= 2'b00;
        end else begin
            r_state  <= w_state_nxt;
            r_target <= w_target_nxt;
            y        <= w_y_nxt;
            Up       <= {(w_target_nxt > w_y_nxt), (w_state_nxt == ST_MOVE_UP)};
            Down     <= {(w_target_nxt < w_y_nxt), (w_state_nxt == ST_MOVE_DOWN)};
            case (w_state_nxt)
                ST_DOOR_OPEN:  door <= c_door_open;
                ST_DOOR_CLOSE: door <= c_door_closing;
                default:       door <= c_door_closed;
            endcase
            case (w_state_nxt)
                ST_IDLE:                     wait_floor <= c_wait_idle;
                ST_DOOR_OPEN, ST_DOOR_CLOSE: wait_floor <= c_wait_serving;
                default:                     wait_floor <= c_wait_moving;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_elevator_controller.sv
//----------------------------------------------------------------------------
// Module   : tb_elevator_controller
// Brief    : Directed trip table plus reset sequences for elevator_controller.
// Revision : 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

module tb_elevator_controller;

    localparam int c_floor_cycles = 4;
    localparam int c_door_cycles  = 4;

    typedef struct {
        logic [4:0] req;
        logic [4:0] alt_req;
        int         change_at;
        logic [4:0] dest;
        logic [1:0] up;
        logic [1:0] down;
        int         edges;
    } trip_t;

    logic       clk;
    logic       reset;
    logic [4:0] requested_floor;
    logic [1:0] wait_floor;
    logic [1:0] door;
    logic [1:0] Up;
    logic [1:0] Down;
    logic [4:0] y;

    int n_checks;
    int n_fail;
    trip_t trips [4];

    elevator_controller #(
        .NUM_FLOORS   (32),
        .FLOOR_CYCLES (c_floor_cycles),
        .DOOR_CYCLES  (c_door_cycles)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .requested_floor (requested_floor),
        .wait_floor      (wait_floor),
        .door            (door),
        .Up              (Up),
        .Down            (Down),
        .y               (y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_idle(input string name, input logic [4:0] floor);
        chk({name, "_y"},    32'(y), 32'(floor));
        chk({name, "_wait"}, 32'(wait_floor), 32'h1);
        chk({name, "_door"}, 32'(door), 32'h0);
        chk({name, "_up"},   32'(Up), 32'h0);
        chk({name, "_down"}, 32'(Down), 32'h0);
    endtask

    task automatic run_trip(input trip_t t);
        int k;
        requested_floor = t.req;
        step();
        k = 0;
        while ((y !== t.dest) && (k < t.edges + 20)) begin
            chk("move_up",   32'(Up), 32'(t.up));
            chk("move_down", 32'(Down), 32'(t.down));
            chk("move_wait", 32'(wait_floor), 32'h0);
            if (k == t.change_at) requested_floor = t.alt_req;
            step();
            k++;
        end
        chk("arrive_y",      32'(y), 32'(t.dest));
        chk("arrive_cycles", 32'(k), 32'(t.edges));
        chk("arrive_up",     32'(Up), 32'h0);
        chk("arrive_down",   32'(Down), 32'h0);
        for (int i = 0; i < c_door_cycles; i++) begin
            chk("door_open",      32'(door), 32'h1);
            chk("door_open_wait", 32'(wait_floor), 32'h2);
            step();
        end
        chk("door_closing",      32'(door), 32'h2);
        chk("door_closing_wait", 32'(wait_floor), 32'h2);
        step();
        chk_idle("after_door", t.dest);
        // A request still held at the arrival floor must not restart anything.
        if (requested_floor == t.dest) begin
            for (int i = 0; i < 3; i++) begin
                step();
                chk_idle("held_req", t.dest);
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        trips[0] = '{req: 5'd12, alt_req: 5'd12, change_at: -1, dest: 5'd12,
                     up: 2'b11, down: 2'b00, edges: 48};
        trips[1] = '{req: 5'd3,  alt_req: 5'd3,  change_at: -1, dest: 5'd3,
                     up: 2'b00, down: 2'b11, edges: 36};
        trips[2] = '{req: 5'd13, alt_req: 5'd5,  change_at: 8,  dest: 5'd13,
                     up: 2'b11, down: 2'b00, edges: 40};
        trips[3] = '{req: 5'd5,  alt_req: 5'd5,  change_at: -1, dest: 5'd5,
                     up: 2'b00, down: 2'b11, edges: 32};

        reset = 1'b0;
        requested_floor = 5'd0;
        step();
        reset = 1'b1;
        chk_idle("reset", 5'd0);
        step();
        step();
        chk_idle("idle_no_req", 5'd0);

        for (int i = 0; i < 4; i++) run_trip(trips[i]);

        // Request equal to the current floor.
        requested_floor = 5'd5;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_idle("same_floor", 5'd5);
        end

        // Reset mid-trip while climbing past floor 7.
        requested_floor = 5'd20;
        step();
        for (int i = 0; i < 2 * c_floor_cycles; i++) step();
        chk("mid_y",  32'(y), 32'd7);
        chk("mid_up", 32'(Up), 32'h3);
        requested_floor = 5'd0;
        reset = 1'b0;
        step();
        reset = 1'b1;
        chk_idle("mid_reset", 5'd0);
        step();
        chk_idle("post_reset", 5'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
